// File: rtl/led_cycle_two_dir_if.sv
// Button-side request flags and LED drive bundle for the bidirectional LED chaser.
// The master drives the flags and observes the LEDs; the slave is the chaser itself.
interface led_cycle_two_dir_if #(
  parameter int LED_W = 4
);
  logic             flag1;
  logic             flag2;
  logic [LED_W-1:0] pio_led;

  modport master (
    output flag1,
    output flag2,
    input  pio_led
  );

  modport slave (
    input  flag1,
    input  flag2,
    output pio_led
  );
endinterface

// File: rtl/led_cycle_two_dir.sv
// One-hot LED chaser rotating left (flag1) or right (flag2) once every STEP_CYCLES clocks.
// First step lands STEP_CYCLES edges after an accepted flag edge; no backpressure, inputs are level flags.
module led_cycle_two_dir #(
  parameter int LED_W       = 4,
  parameter int STEP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  led_cycle_two_dir_if.slave led
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             flag1_d, flag2_d;

  logic rise1, rise2;
  logic req_left, req_right;
  logic step_due;

  // A flag already high when reset releases counts as an edge, since the delayed copy is 0.
  assign rise1     = led.flag1 & ~flag1_d;
  assign rise2     = led.flag2 & ~flag2_d;
  assign req_left  = rise1 & ~rise2;
  assign req_right = rise2 & ~rise1;
  assign step_due  = (cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      led_q   <= LED_W'(1);
      flag1_d <= 1'b0;
      flag2_d <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      flag1_d <= led.flag1;
      flag2_d <= led.flag2;
    end
  end

  // Simultaneous rises fall through to plain stepping, so the step phase is preserved.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_left) begin
          state_d = LEFT;
        end else if (req_right) begin
          state_d = RIGHT;
        end
      end
      LEFT: begin
        if (req_right) begin
          state_d = RIGHT;
          cnt_d   = '0;
        end else if (step_due) begin
          cnt_d = '0;
          led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RIGHT: begin
        if (req_left) begin
          state_d = LEFT;
          cnt_d   = '0;
        end else if (step_due) begin
          cnt_d = '0;
          led_d = {led_q[0], led_q[LED_W-1:1]};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign led.pio_led = led_q;

endmodule

// File: tb/tb_led_cycle_two_dir.sv
// Directed bench for the LED chaser: cycle-by-cycle vector table plus a STEP_CYCLES=1 sequence.
module tb_led_cycle_two_dir;
  localparam int LED_W = 4;

  logic clk = 1'b0;
  logic rst_n;

  led_cycle_two_dir_if #(.LED_W(LED_W)) bus  ();
  led_cycle_two_dir_if #(.LED_W(LED_W)) bus1 ();

  assign bus1.flag1 = bus.flag1;
  assign bus1.flag2 = bus.flag2;

  led_cycle_two_dir #(.LED_W(LED_W), .STEP_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .led   (bus)
  );

  led_cycle_two_dir #(.LED_W(LED_W), .STEP_CYCLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .led   (bus1)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             f1;
    logic             f2;
    logic [LED_W-1:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic r, input logic a, input logic b,
                     input logic [LED_W-1:0] e, input int n = 1);
    vec_t v;
    v.rst = r;
    v.f1  = a;
    v.f2  = b;
    v.exp = e;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic cyc(input logic r, input logic a, input logic b);
    rst_n     = r;
    bus.flag1 = a;
    bus.flag2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [LED_W-1:0] act,
                       input logic [LED_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: pio_led=%b expected %b", name, act, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b1;
    bus.flag1 = 1'b0;
    bus.flag2 = 1'b0;

    // Reset then idle
    add(1, 0, 0, 4'b0001, 10);
    add(0, 0, 0, 4'b0001, 6);
    // flag1 pulse at N: left rotation with wrap
    add(0, 1, 0, 4'b0001);
    add(0, 0, 0, 4'b0001, 3);
    add(0, 0, 0, 4'b0010, 4);
    add(0, 0, 0, 4'b0100, 4);
    add(0, 0, 0, 4'b1000, 4);
    add(0, 0, 0, 4'b0001, 4);
    add(0, 0, 0, 4'b0010, 4);
    add(0, 0, 0, 4'b0100, 2);
    // flag2 pulse at M with 0100 lit: reverse, no change on the switching edge
    add(0, 0, 1, 4'b0100);
    add(0, 0, 0, 4'b0100, 3);
    add(0, 0, 0, 4'b0010, 4);
    add(0, 0, 0, 4'b0001, 4);
    add(0, 0, 0, 4'b1000);
    // Both flags rise together in RIGHT: ignored, phase kept
    add(0, 1, 1, 4'b1000, 3);
    add(0, 1, 1, 4'b0100);
    add(0, 0, 0, 4'b0100, 3);
    add(0, 0, 0, 4'b0010, 2);
    // Same-direction rise in RIGHT: no effect
    add(0, 0, 1, 4'b0010);
    add(0, 0, 0, 4'b0010);
    add(0, 0, 0, 4'b0001, 4);
    add(0, 0, 0, 4'b1000);
    // Reset mid-rotation, flag1 already high at release, then held 20 cycles
    add(1, 0, 0, 4'b0001);
    add(1, 1, 0, 4'b0001);
    add(0, 1, 0, 4'b0001, 4);
    add(0, 1, 0, 4'b0010, 4);
    add(0, 1, 0, 4'b0100, 4);
    add(0, 1, 0, 4'b1000, 4);
    add(0, 1, 0, 4'b0001, 4);
    // Re-pulse flag1 while LEFT: step phase undisturbed
    add(0, 0, 0, 4'b0010);
    add(0, 1, 0, 4'b0010);
    add(0, 0, 0, 4'b0010, 2);
    add(0, 0, 0, 4'b0100);
    // Both flags rise together from IDLE: stays IDLE, then a lone flag2 still starts RIGHT
    add(1, 0, 0, 4'b0001, 2);
    add(0, 0, 0, 4'b0001, 2);
    add(0, 1, 1, 4'b0001);
    add(0, 0, 0, 4'b0001, 8);
    add(0, 0, 1, 4'b0001);
    add(0, 0, 0, 4'b0001, 3);
    add(0, 0, 0, 4'b1000);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].f1, vecs[i].f2);
      check($sformatf("vec%0d", i), bus.pio_led, vecs[i].exp);
    end

    // STEP_CYCLES=1: first step one edge after the event, then every cycle
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("s1_reset", bus1.pio_led, 4'b0001);
    cyc(0, 1, 0);
    check("s1_accept", bus1.pio_led, 4'b0001);
    cyc(0, 0, 0);
    check("s1_step1", bus1.pio_led, 4'b0010);
    cyc(0, 0, 0);
    check("s1_step2", bus1.pio_led, 4'b0100);
    cyc(0, 0, 0);
    check("s1_step3", bus1.pio_led, 4'b1000);
    cyc(0, 0, 0);
    check("s1_wrap", bus1.pio_led, 4'b0001);
    cyc(0, 0, 1);
    check("s1_switch", bus1.pio_led, 4'b0001);
    cyc(0, 0, 0);
    check("s1_right1", bus1.pio_led, 4'b1000);
    cyc(0, 0, 0);
    check("s1_right2", bus1.pio_led, 4'b0100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
